// File: rtl/multicore_mem_arbiter.sv
// ---------------------------------------------------------------------------
// multicore_mem_arbiter
//
// Purpose:
//   Merges the N per-core picorv32 native memory interfaces of the multicore
//   cluster onto one shared single-port memory bus. Exactly one transaction
//   is outstanding at a time. Simultaneous requests are resolved in
//   round-robin order starting after the last granted core. The response is
//   routed back only to the core that owns the transaction.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        asynchronous active-high reset, clears all state at once
//   core_valid   per-core request valid (picorv32 mem_valid)
//   core_instr   per-core instruction-fetch flag
//   core_addr    per-core byte address
//   core_wdata   per-core write data
//   core_wstrb   per-core byte strobes, zero means read
//   core_ready   per-core one-cycle completion pulse
//   core_rdata   per-core read data, valid while core_ready is high and held
//                until that core's next completion
//   mem_valid    shared-bus request valid
//   mem_instr    forwarded instruction flag
//   mem_addr     forwarded address
//   mem_wdata    forwarded write data
//   mem_wstrb    forwarded strobes
//   mem_ready    shared-bus completion, only looked at while busy
//   mem_rdata    shared-bus read data, captured together with mem_ready
//   grant_id     index of the core owning the current or last transaction
// ---------------------------------------------------------------------------
module multicore_mem_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         core_valid,
  input  logic [N-1:0]         core_instr,
  input  logic [N-1:0][31:0]   core_addr,
  input  logic [N-1:0][31:0]   core_wdata,
  input  logic [N-1:0][3:0]    core_wstrb,
  output logic [N-1:0]         core_ready,
  output logic [N-1:0][31:0]   core_rdata,
  output logic                 mem_valid,
  output logic                 mem_instr,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic                 mem_ready,
  input  logic [31:0]          mem_rdata,
  output logic [IW-1:0]        grant_id
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_last;
  logic [IW-1:0] w_sel;
  logic [IW-1:0] w_cand;
  logic          w_found;
  logic          w_any;

  // Round-robin pick: walk the cores starting one past the last grant and
  // wrap around, taking the first one that is requesting. Visiting the last
  // granted core at the very end of the walk is what gives every other
  // requester priority over it.
  always_comb begin
    w_any   = |core_valid;
    w_sel   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IW'((int'(r_last) + k) % N);
      if (!w_found && core_valid[w_cand]) begin
        w_sel   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  // State register. Reset drops straight into IDLE so any transaction in
  // flight is simply abandoned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. IDLE waits for any request, BUSY waits for the memory
  // to complete, and RESP is the single cycle in which the owner sees its
  // ready pulse before we go back to arbitrate again.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_any) w_next = ST_BUSY;
      ST_BUSY: if (mem_ready) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath registers. The selected core's request is latched at grant
  // time, so the bus sees stable values for the whole BUSY phase even if
  // the core changes its inputs or drops valid. The response lands only in
  // the owner's rdata slot, and on writes too, so other cores keep their
  // last read value. The last-grant pointer resets to N-1 so core 0 wins
  // the first arbitration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_ready <= '0;
      core_rdata <= '0;
      mem_valid  <= 1'b0;
      mem_instr  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      grant_id   <= '0;
      r_last     <= IW'(N - 1);
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            mem_valid <= 1'b1;
            mem_instr <= core_instr[w_sel];
            mem_addr  <= core_addr[w_sel];
            mem_wdata <= core_wdata[w_sel];
            mem_wstrb <= core_wstrb[w_sel];
            grant_id  <= w_sel;
            r_last    <= w_sel;
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            mem_valid            <= 1'b0;
            core_rdata[grant_id] <= mem_rdata;
            core_ready[grant_id] <= 1'b1;
          end
        end
        ST_RESP: begin
          core_ready <= '0;
        end
        default: begin
          core_ready <= '0;
          mem_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicore_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_multicore_mem_arbiter
//
// Purpose:
//   Directed, self-checking bench for multicore_mem_arbiter. A two-core
//   instance covers single reads, first arbitration after reset, write
//   forwarding with wait cycles, long wait states and an asynchronous reset
//   in the middle of a transaction. A four-core instance with a zero-wait
//   memory covers sustained round-robin contention.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_multicore_mem_arbiter;

  logic clk;
  logic reset;

  logic [1:0]        cv2;
  logic [1:0]        ci2;
  logic [1:0][31:0]  ca2;
  logic [1:0][31:0]  cw2;
  logic [1:0][3:0]   cs2;
  logic [1:0]        cr2;
  logic [1:0][31:0]  crd2;
  logic              mv2;
  logic              mi2;
  logic [31:0]       ma2;
  logic [31:0]       mw2;
  logic [3:0]        ms2;
  logic              mr2;
  logic [31:0]       mrd2;
  logic [0:0]        gid2;

  logic [3:0]        cv4;
  logic [3:0]        ci4;
  logic [3:0][31:0]  ca4;
  logic [3:0][31:0]  cw4;
  logic [3:0][3:0]   cs4;
  logic [3:0]        cr4;
  logic [3:0][31:0]  crd4;
  logic              mv4;
  logic              mi4;
  logic [31:0]       ma4;
  logic [31:0]       mw4;
  logic [3:0]        ms4;
  logic              mr4;
  logic [31:0]       mrd4;
  logic [1:0]        gid4;

  int checks;
  int failures;

  multicore_mem_arbiter #(.N(2)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .core_valid (cv2),
    .core_instr (ci2),
    .core_addr  (ca2),
    .core_wdata (cw2),
    .core_wstrb (cs2),
    .core_ready (cr2),
    .core_rdata (crd2),
    .mem_valid  (mv2),
    .mem_instr  (mi2),
    .mem_addr   (ma2),
    .mem_wdata  (mw2),
    .mem_wstrb  (ms2),
    .mem_ready  (mr2),
    .mem_rdata  (mrd2),
    .grant_id   (gid2)
  );

  multicore_mem_arbiter #(.N(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .core_valid (cv4),
    .core_instr (ci4),
    .core_addr  (ca4),
    .core_wdata (cw4),
    .core_wstrb (cs4),
    .core_ready (cr4),
    .core_rdata (crd4),
    .mem_valid  (mv4),
    .mem_instr  (mi4),
    .mem_addr   (ma4),
    .mem_wdata  (mw4),
    .mem_wstrb  (ms4),
    .mem_ready  (mr4),
    .mem_rdata  (mrd4),
    .grant_id   (gid4)
  );

  // Free-running 100 MHz-style clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where inputs are driven and
  // outputs are sampled, well away from the edge itself.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one core of the two-core instance.
  task automatic applyStimulus(input int core, input logic v, input logic instr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb);
    cv2[core] = v;
    ci2[core] = instr;
    ca2[core] = addr;
    cw2[core] = wdata;
    cs2[core] = wstrb;
  endtask

  // One comparison against a bench-computed expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Directed sequence: each step drives inputs, advances the clock and
  // compares outputs against hand-computed values.
  initial begin
    int g;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    cv2 = '0; ci2 = '0; ca2 = '0; cw2 = '0; cs2 = '0;
    mr2 = 1'b0; mrd2 = '0;
    cv4 = '0; ci4 = '0; cw4 = '0; cs4 = '0;
    for (int i = 0; i < 4; i++) ca4[i] = 32'(i * 16);
    mr4 = 1'b1; mrd4 = 32'h1234_5678;

    // Reset state
    tick();
    tick();
    checkOutput("rst_mem_valid", 32'(mv2), 32'h0);
    checkOutput("rst_core_ready", 32'(cr2), 32'h0);
    checkOutput("rst_grant_id", 32'(gid2), 32'h0);
    checkOutput("rst_mem_addr", ma2, 32'h0);
    checkOutput("rst_mem_wdata", mw2, 32'h0);
    checkOutput("rst_mem_wstrb", 32'(ms2), 32'h0);
    checkOutput("rst_mem_instr", 32'(mi2), 32'h0);
    checkOutput("rst_rdata0", crd2[0], 32'h0);
    checkOutput("rst_rdata1", crd2[1], 32'h0);
    checkOutput("rst4_mem_valid", 32'(mv4), 32'h0);
    reset = 1'b0;
    tick();
    checkOutput("idle_no_req", 32'(mv2), 32'h0);

    // Single read from core 0
    $display("[TB] single read");
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    tick();
    checkOutput("rd_mem_valid", 32'(mv2), 32'h1);
    checkOutput("rd_mem_addr", ma2, 32'h0000_0010);
    checkOutput("rd_mem_wstrb", 32'(ms2), 32'h0);
    checkOutput("rd_grant", 32'(gid2), 32'h0);
    checkOutput("rd_no_early_ready", 32'(cr2), 32'h0);
    mr2 = 1'b1; mrd2 = 32'h3fc0_0093;
    tick();
    checkOutput("rd_ready_pulse", 32'(cr2), 32'h1);
    checkOutput("rd_rdata0", crd2[0], 32'h3fc0_0093);
    checkOutput("rd_mem_valid_low", 32'(mv2), 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mr2 = 1'b0; mrd2 = 32'h0;
    tick();
    checkOutput("rd_ready_one_cycle", 32'(cr2), 32'h0);
    checkOutput("rd_rdata0_held", crd2[0], 32'h3fc0_0093);
    tick();
    checkOutput("rd_idle_after", 32'(mv2), 32'h0);

    // First arbitration after reset: both cores request together
    $display("[TB] first arbitration after reset");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
    tick();
    checkOutput("arb_first_grant", 32'(gid2), 32'h0);
    checkOutput("arb_first_addr", ma2, 32'h0000_0100);
    mr2 = 1'b1; mrd2 = 32'h1111_1111;
    tick();
    checkOutput("arb_ready0", 32'(cr2), 32'h1);
    checkOutput("arb_gap1", 32'(mv2), 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mr2 = 1'b0;
    tick();
    checkOutput("arb_gap2", 32'(mv2), 32'h0);
    checkOutput("arb_ready_cleared", 32'(cr2), 32'h0);
    tick();
    checkOutput("arb_second_valid", 32'(mv2), 32'h1);
    checkOutput("arb_second_grant", 32'(gid2), 32'h1);
    checkOutput("arb_second_addr", ma2, 32'h0000_0200);
    mr2 = 1'b1; mrd2 = 32'h2222_2222;
    tick();
    checkOutput("arb_ready1", 32'(cr2), 32'h2);
    checkOutput("arb_rdata1", crd2[1], 32'h2222_2222);
    checkOutput("arb_rdata0_kept", crd2[0], 32'h1111_1111);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mr2 = 1'b0;
    tick();

    // Write forwarding from core 1, held through three wait cycles while
    // core 0 starts requesting with different values
    $display("[TB] write forwarding");
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_03FC, 32'hA5A5_A5A5, 4'b0110);
    tick();
    checkOutput("wr_grant", 32'(gid2), 32'h1);
    checkOutput("wr_addr", ma2, 32'h0000_03FC);
    checkOutput("wr_wdata", mw2, 32'hA5A5_A5A5);
    checkOutput("wr_wstrb", 32'(ms2), 32'h6);
    applyStimulus(0, 1'b1, 1'b1, 32'h0000_0020, 32'h5555_0000, 4'h0);
    for (int w = 0; w < 3; w++) begin
      tick();
      checkOutput("wr_hold_valid", 32'(mv2), 32'h1);
      checkOutput("wr_hold_addr", ma2, 32'h0000_03FC);
      checkOutput("wr_hold_wdata", mw2, 32'hA5A5_A5A5);
      checkOutput("wr_hold_wstrb", 32'(ms2), 32'h6);
      checkOutput("wr_hold_grant", 32'(gid2), 32'h1);
      checkOutput("wr_no_ready", 32'(cr2), 32'h0);
    end
    mr2 = 1'b1; mrd2 = 32'hDEAD_BEEF;
    tick();
    checkOutput("wr_ready1", 32'(cr2), 32'h2);
    checkOutput("wr_rdata1", crd2[1], 32'hDEAD_BEEF);
    checkOutput("wr_rdata0_kept", crd2[0], 32'h1111_1111);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mr2 = 1'b0;
    tick();

    // Wait states: core 0 (still requesting) is granted, memory answers
    // only in the sixth cycle of mem_valid
    $display("[TB] wait states");
    tick();
    checkOutput("ws_grant", 32'(gid2), 32'h0);
    checkOutput("ws_valid_c1", 32'(mv2), 32'h1);
    checkOutput("ws_addr", ma2, 32'h0000_0020);
    checkOutput("ws_instr", 32'(mi2), 32'h1);
    for (int w = 2; w <= 6; w++) begin
      tick();
      checkOutput("ws_valid_held", 32'(mv2), 32'h1);
      checkOutput("ws_no_ready", 32'(cr2), 32'h0);
    end
    mr2 = 1'b1; mrd2 = 32'hCAFE_F00D;
    tick();
    checkOutput("ws_valid_drop", 32'(mv2), 32'h0);
    checkOutput("ws_ready0", 32'(cr2), 32'h1);
    checkOutput("ws_rdata0", crd2[0], 32'hCAFE_F00D);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mr2 = 1'b0;
    tick();
    checkOutput("ws_ready_cleared", 32'(cr2), 32'h0);

    // Asynchronous reset in the middle of a BUSY phase
    $display("[TB] reset mid-busy");
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0444, 32'h0, 4'h0);
    tick();
    checkOutput("rb_valid_before", 32'(mv2), 32'h1);
    checkOutput("rb_grant_before", 32'(gid2), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rb_async_valid", 32'(mv2), 32'h0);
    checkOutput("rb_async_ready", 32'(cr2), 32'h0);
    checkOutput("rb_async_grant", 32'(gid2), 32'h0);
    checkOutput("rb_async_addr", ma2, 32'h0);
    mr2 = 1'b1; mrd2 = 32'hFFFF_FFFF;
    tick();
    checkOutput("rb_held_ready", 32'(cr2), 32'h0);
    reset = 1'b0;
    mr2 = 1'b0;
    tick();
    checkOutput("rb_regrant_valid", 32'(mv2), 32'h1);
    checkOutput("rb_regrant_grant", 32'(gid2), 32'h1);
    checkOutput("rb_no_stale_ready", 32'(cr2), 32'h0);
    mr2 = 1'b1; mrd2 = 32'h0BAD_F00D;
    tick();
    checkOutput("rb_ready1", 32'(cr2), 32'h2);
    checkOutput("rb_rdata1", crd2[1], 32'h0BAD_F00D);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mr2 = 1'b0;
    tick();
    checkOutput("rb_ready_cleared", 32'(cr2), 32'h0);

    // Sustained contention on the four-core instance, zero-wait memory:
    // a grant every 3 cycles, order 0,1,2,3,0,... and one pulse per core
    // every 12 cycles
    $display("[TB] four-core contention");
    cv4 = 4'hF;
    tick();
    g = 0;
    for (int c = 0; c < 24; c++) begin
      case (c % 3)
        0: begin
          checkOutput("rr_valid", 32'(mv4), 32'h1);
          checkOutput("rr_grant", 32'(gid4), 32'(g));
          checkOutput("rr_addr", ma4, 32'(g * 16));
          checkOutput("rr_no_ready", 32'(cr4), 32'h0);
        end
        1: begin
          checkOutput("rr_ready_pulse", 32'(cr4), 32'(1 << g));
          checkOutput("rr_valid_low", 32'(mv4), 32'h0);
        end
        default: begin
          checkOutput("rr_ready_low", 32'(cr4), 32'h0);
          checkOutput("rr_idle_low", 32'(mv4), 32'h0);
          g = (g + 1) % 4;
        end
      endcase
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
